// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit channel among NUM_REQ
// byte-stream requesters. A grant is held until the owner sends its last
// byte or reaches the MAX_BURST cap (0 = no cap). Bytes pass straight
// through combinationally while a grant is held.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; pick the next requester round-robin after last_owner
// GRANT | owner_q connected to the tx channel until last byte or cap

module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    localparam int SRC_W    = $clog2(NUM_REQ),
    localparam int BC_W     = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_valid,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_ready,
    output logic [SRC_W-1:0]          tx_src,
    output logic                      busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   owner_q, owner_d;
    logic [SRC_W-1:0]   last_owner_q, last_owner_d;
    logic [BC_W-1:0]    burst_cnt_q, burst_cnt_d;

    logic [SRC_W-1:0]   pick;
    logic               pick_found;
    logic               xfer;
    logic               cap_hit;

    // Round-robin search starting just after the previous owner, so the
    // previous owner is considered last.
    always_comb begin
        logic [SRC_W-1:0] idx;
        idx        = '0;
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = SRC_W'((int'(last_owner_q) + k) % NUM_REQ);
            if (!pick_found && req_valid[idx]) begin
                pick       = idx;
                pick_found = 1'b1;
            end
        end
    end

    // Next-state and pass-through outputs; everything is zero outside GRANT.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        tx_valid     = 1'b0;
        tx_data      = '0;
        req_ready    = '0;
        busy         = 1'b0;
        xfer         = 1'b0;
        cap_hit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d      = GRANT;
                    owner_d      = pick;
                    last_owner_d = pick;
                    burst_cnt_d  = '0;
                end
            end
            GRANT: begin
                busy               = 1'b1;
                tx_valid           = req_valid[owner_q];
                tx_data            = req_data[int'(owner_q)*DATA_W +: DATA_W];
                req_ready[owner_q] = tx_ready;
                xfer               = tx_valid && tx_ready;
                cap_hit            = (MAX_BURST > 0) &&
                                     (int'(burst_cnt_q) + 1 == MAX_BURST);
                if (xfer) begin
                    // Saturate rather than wrap; unused when MAX_BURST is 0.
                    if (int'(burst_cnt_q) < MAX_BURST) begin
                        burst_cnt_d = burst_cnt_q + BC_W'(1);
                    end
                    if (req_last[owner_q] || cap_hit) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; last_owner resets to NUM_REQ-1 so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= SRC_W'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    assign tx_src = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios followed by a random
// phase, all checked cycle by cycle against a transaction-level model.

module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [W-1:0]   tx_data;
    logic           tx_ready;
    logic [1:0]     tx_src;
    logic           busy;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .tx_src(tx_src), .busy(busy)
    );

    always #5 clk = ~clk;

    // Requester sources: per-requester byte queues plus a valid gate.
    bit [7:0] q_data[N][$];
    bit       q_last[N][$];
    bit       en[N];

    // Bytes observed on the tx side, and expected sequences.
    int log_src[$];
    int log_dat[$];
    int e_src[$];
    int e_dat[$];

    // Transaction-level model: who holds the grant and how many bytes sent.
    bit m_busy;
    int m_owner;
    int m_last;
    int m_cnt;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] rv, input int last);
        for (int k = 1; k <= N; k++) begin
            if (((rv >> ((last + k) % N)) & 1) != 0) return (last + k) % N;
        end
        return 0;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (en[i] && q_data[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[i*W +: W] = q_data[i][0];
                req_last[i]        = q_last[i][0];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*W +: W] = '0;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = N - 1;
        m_cnt   = 0;
    endtask

    task automatic push_byte(input int r, input int d, input bit last);
        q_data[r].push_back(8'(d));
        q_last[r].push_back(last);
    endtask

    task automatic push_pkt(input int r, input int first, input int len);
        for (int k = 0; k < len; k++) push_byte(r, first + k, k == len - 1);
    endtask

    task automatic push_exp(input int s, input int d);
        e_src.push_back(s);
        e_dat.push_back(d);
    endtask

    // One clock cycle: compare at the falling edge, then advance the model
    // and the sources after the rising edge.
    task automatic cycle();
        logic [N-1:0]   rv, rl, hs;
        logic [N*W-1:0] rd;
        logic           txr;
        logic [31:0]    exp_v, exp_r;
        @(negedge clk);
        rv = req_valid; rl = req_last; rd = req_data; txr = tx_ready;
        exp_v = 0; exp_r = 0;
        if (m_busy) begin
            exp_v = (rv >> m_owner) & 1;
            exp_r = txr ? (32'd1 << m_owner) : 32'd0;
        end
        chk("busy", 32'(busy), 32'(m_busy));
        chk("tx_valid", 32'(tx_valid), exp_v);
        chk("req_ready", 32'(req_ready), exp_r);
        if (m_busy) begin
            chk("tx_src", 32'(tx_src), m_owner);
            chk("tx_data", 32'(tx_data), (rd >> (m_owner * W)) & 32'hFF);
        end
        hs = rv & req_ready;
        if (tx_valid && tx_ready) begin
            log_src.push_back(int'(tx_src));
            log_dat.push_back(int'(tx_data));
        end
        @(posedge clk);
        #1;
        if (m_busy) begin
            if ((((rv >> m_owner) & 1) != 0) && txr) begin
                m_cnt++;
                if ((((rl >> m_owner) & 1) != 0) || (MB > 0 && m_cnt == MB)) m_busy = 1'b0;
            end
        end else if (rv != 0) begin
            m_owner = rr_pick(rv, m_last);
            m_last  = m_owner;
            m_cnt   = 0;
            m_busy  = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                void'(q_data[i].pop_front());
                void'(q_last[i].pop_front());
            end
        end
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    function automatic int pending();
        int p = 0;
        for (int i = 0; i < N; i++) p += q_data[i].size();
        return p;
    endfunction

    task automatic drain(input string tag, input int limit);
        int n = 0;
        while (pending() > 0 && n < limit) begin
            cycle();
            n++;
        end
        chk({tag, "_drained"}, pending(), 0);
        run(2);
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_len"}, log_dat.size(), e_dat.size());
        for (int k = 0; k < e_dat.size() && k < log_dat.size(); k++) begin
            chk({tag, "_src"}, log_src[k], e_src[k]);
            chk({tag, "_dat"}, log_dat[k], e_dat[k]);
        end
        log_src.delete(); log_dat.delete(); e_src.delete(); e_dat.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
    endtask

    initial begin
        int pushed;
        rst = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        drive();
        do_reset();

        // Reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_tx_src", 32'(tx_src), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        run(2);

        // Single requester
        push_byte(2, 8'hAA, 1'b1);
        drive();
        run(1);
        chk("single_latency", 32'(tx_valid), 1);
        drain("single", 20);
        chk("single_idle", 32'(busy), 0);
        push_exp(2, 8'hAA);
        chk_log("single");

        // Round-robin from a fresh reset
        do_reset();
        for (int i = 0; i < N; i++) push_pkt(i, 8'h10 + i, 1);
        push_pkt(0, 8'h14, 1);
        drive();
        drain("rr", 50);
        for (int i = 0; i < N; i++) push_exp(i, 8'h10 + i);
        push_exp(0, 8'h14);
        chk_log("rr");

        // Burst cap
        push_pkt(1, 8'h33, 6);
        push_pkt(3, 8'h77, 1);
        drive();
        drain("burst", 50);
        for (int k = 0; k < 4; k++) push_exp(1, 8'h33 + k);
        push_exp(3, 8'h77);
        push_exp(1, 8'h37);
        push_exp(1, 8'h38);
        chk_log("burst");

        // Backpressure
        push_byte(0, 8'h3C, 1'b0);
        push_byte(0, 8'h3C, 1'b1);
        drive();
        run(2);
        tx_ready = 1'b0;
        run(5);
        tx_ready = 1'b1;
        drain("bp", 20);
        push_exp(0, 8'h3C);
        push_exp(0, 8'h3C);
        chk_log("bp");

        // Owner gap while another requester waits
        push_pkt(2, 8'h51, 3);
        push_pkt(3, 8'h61, 1);
        drive();
        run(2);
        en[2] = 1'b0;
        drive();
        run(3);
        chk("gap_busy", 32'(busy), 1);
        chk("gap_src", 32'(tx_src), 2);
        en[2] = 1'b1;
        drive();
        drain("gap", 20);
        for (int k = 0; k < 3; k++) push_exp(2, 8'h51 + k);
        push_exp(3, 8'h61);
        chk_log("gap");

        // Reset mid-packet
        push_pkt(0, 8'h81, 4);
        push_pkt(1, 8'h91, 1);
        drive();
        run(3);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_tx_valid", 32'(tx_valid), 0);
        chk("mid_rst_req_ready", 32'(req_ready), 0);
        chk("mid_rst_tx_src", 32'(tx_src), 0);
        chk("mid_rst_tx_data", 32'(tx_data), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        drain("mid_rst", 30);
        for (int k = 0; k < 4; k++) push_exp(0, 8'h81 + k);
        push_exp(1, 8'h91);
        chk_log("mid_rst");

        // Random traffic, gaps and backpressure
        pushed = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(7) == 0) begin
                int r, len;
                r   = $urandom_range(N - 1);
                len = $urandom_range(6, 1);
                for (int k = 0; k < len; k++) push_byte(r, $urandom_range(255), k == len - 1);
                pushed += len;
            end
            for (int i = 0; i < N; i++) en[i] = ($urandom_range(4) != 0);
            tx_ready = ($urandom_range(3) != 0);
            drive();
            cycle();
        end
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        tx_ready = 1'b1;
        drive();
        drain("rand", 2000);
        chk("rand_count", log_dat.size(), pushed);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmit channel among NUM_REQ byte-stream requesters. It grants one requester at a time and passes that requester's bytes to the downstream uart transmitter over a valid/ready interface. The grant is held until the requester ends its packet or hits a burst cap. It sits between the client logic and the uart tx serializer, clocked at the system clock.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 8, bits per character
MAX_BURST, 4, max bytes per grant before forced re-arbitration; 0 = unlimited (packet ends only on req_last)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  marks last byte of requester's packet
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
tx_valid  out  1  byte valid to uart tx
tx_data  out  DATA_W  byte to uart tx
tx_ready  in  1  uart tx can accept byte
tx_src  out  clog2(NUM_REQ)  index of current owner; valid while busy=1
busy  out  1  1 while a grant is held

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, tx_valid=0, tx_data=0, req_ready=0, tx_src=0, busy=0, burst_cnt=0, last_owner=NUM_REQ-1 (so requester 0 has first priority).
- FSM states: IDLE, GRANT.
- IDLE:
  - tx_valid=0 and req_ready=0.
  - If any req_valid is set, select the first set bit searching from last_owner+1 upward, modulo NUM_REQ.
  - Register the selection as owner and tx_src, set last_owner=owner, clear burst_cnt, and go to GRANT on the next edge.
- GRANT, combinational pass-through:
  - tx_valid = req_valid[owner], tx_data = req_data[owner].
  - req_ready[owner] = tx_ready; all other req_ready bits are 0.
  - busy=1.
- Transfer: a byte transfers when tx_valid && tx_ready. Each transfer increments burst_cnt.
- Leaving GRANT: go to IDLE on a transfer with req_last[owner]=1, or a transfer where burst_cnt+1 == MAX_BURST (MAX_BURST>0). Otherwise stay in GRANT.
- Latency:
  - req_valid rising in IDLE -> tx_valid one cycle later.
  - One idle bubble cycle between consecutive grants.
  - Within a grant, back-to-back bytes need no bubble.
- Owner gaps: if the owner drops req_valid mid-packet, the grant is held and tx_valid=0 until it resumes. There is no timeout.
- Backpressure: tx_ready=0 stalls. tx_data must stay stable while tx_valid=1 && tx_ready=0, which is the requester's obligation under the valid/ready rule; the arbiter must not change owner while stalled.
- Non-owner req_valid is ignored during GRANT and never dropped. It is seen at the next IDLE.
- Fairness: after a grant ends, the previous owner is lowest priority. With N requesters continuously valid, each gets a grant within N grants.
- burst_cnt width is clog2(MAX_BURST+1). It saturates and never wraps; with MAX_BURST=0 it is unused.
- Reset mid-packet: outputs return to reset values immediately. A partial packet is abandoned, and the requester must re-request.
- Simultaneous events: req_last and burst-cap reached on the same transfer -> single return to IDLE. req_valid from all requesters in the same IDLE cycle -> round-robin pick only.
- No byte is duplicated or lost. Bytes reach tx in the requester's order.

Test Plan:
- Single requester: req 2 sends 0xAA with last=1 -> tx_valid one cycle after request, tx_data=0xAA, tx_src=2, req_ready[2] only; IDLE afterwards with busy=0.
- Round-robin: all 4 requesters valid with single-byte packets 0x10,0x11,0x12,0x13 -> tx order 0x10,0x11,0x12,0x13 (src 0,1,2,3), then src 0 again; one bubble between each.
- Burst cap: MAX_BURST=4, requester 1 streams 6 bytes 0x33..0x38 with last on the 6th, requester 3 also valid -> 0x33..0x36 from src 1, then src 3 granted, then src 1 resumes with 0x37,0x38.
- Backpressure: tx_ready held 0 for 5 cycles mid-packet 0x3C,0x3C -> tx_valid and tx_data stable and owner unchanged throughout; both bytes delivered once, none lost.
- Owner gap: owner drops req_valid for 3 cycles mid-packet while another requester is valid -> grant held, tx_valid=0 during the gap, no switch until req_last.
- Reset mid-packet: assert rst between the 2nd and 3rd bytes -> all outputs 0 within the reset cycle; after release, requester 0 wins first arbitration.
